sys_bridge_nd: RTL and testbench
================================

Name: sys_bridge_nd

Overview:
- Parametrised system bridge between the CPU data-memory port and NDEV memory-mapped peripherals (timers and similar).
- Each device gets a 16-byte window starting at BASE. Per-device interrupts are collected into HWInt.
- Accesses use a registered request/acknowledge handshake with wait states; the CPU is stalled until the bridge raises PrRdy.
- Misses complete with a zero read; devices that never answer end the access with a bus error.

Parameters:
- NDEV, 2, number of devices; legal range 1..6.
- BASE, 12'h7f0, PrAddr[15:4] value of device 0; device k decodes at BASE+k.
- TIMEOUT, 16, maximum BUSY cycles before abort; must be ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- PrAddr  in  32  CPU byte address.
- PrWD  in  32  CPU write data.
- PrWE  in  1  write strobe; 1 = write, 0 = read.
- PrReq  in  1  access valid; held by the CPU until PrRdy.
- PrRdy  out  1  one-cycle completion pulse.
- PrRD  out  32  read data; valid while PrRdy=1.
- BusErr  out  1  high with PrRdy when the access timed out.
- DEV_Addr  out  2  latched PrAddr[3:2].
- DEV_WD  out  32  latched write data, common to all devices.
- DEV_Req  out  NDEV  one-hot request to the selected device.
- DEV_WE  out  NDEV  one-hot write enable, valid with DEV_Req.
- DEV_Ack  in  NDEV  device acknowledge.
- DEV_RD  in  32*NDEV  flattened read data; device k occupies bits [32k+31:32k].
- IRQ  in  NDEV  device interrupt lines.
- HWInt  out  6  {zero pad, IRQ} to the CP0 Cause IP field.

Behaviour:
- Decode: hit[k] = (PrAddr[15:4] == BASE+k).
  - At most one hit by construction.
  - Bits outside [15:4] are ignored.
- States: IDLE, BUSY, RESP.
- IDLE:
  - PrReq & hit[k] at an edge: latch k, PrAddr[3:2], PrWD, PrWE; enter BUSY; clear the timeout counter.
  - PrReq with no hit: enter RESP with rd_q = 0, BusErr = 0. Miss writes are silently dropped.
  - No PrReq: remain in IDLE.
- BUSY:
  - DEV_Req[k] = 1 and DEV_WE[k] = latched WE; all other bits are 0.
  - DEV_Ack[k] = 1 at an edge: rd_q <= DEV_RD[k]; enter RESP; BusErr stays 0.
  - DEV_Ack on any bit other than k is ignored.
  - No ack: the counter increments.
- RESP:
  - PrRdy = 1 for exactly one cycle; PrRD = rd_q.
  - Always returns to IDLE.
  - PrReq seen in RESP is not accepted. The next access starts from IDLE, so back-to-back accesses have a one-cycle bubble.
- Registered outputs: all outputs are registered or decoded from state only, except HWInt.
  - DEV_Req, DEV_WE, PrRdy and BusErr drop the cycle after leaving their state.
- Latency:
  - Hit with the device acking in its first DEV_Req cycle: PrReq at cycle 0, DEV_Req at cycle 1, PrRdy at cycle 2.
  - Miss: PrRdy at cycle 1.
- Write data: DEV_WD and DEV_Addr hold their latched values throughout BUSY. PrWD changing mid-access has no effect.
- Interrupts: HWInt = {(6-NDEV) zeros, IRQ}, combinational and independent of the FSM.
- Reset (reset=0, any state, asynchronous): state = IDLE, counter = 0, rd_q = 0, latched fields = 0. All outputs read 0 except HWInt, which still tracks IRQ.
  - An access in flight is lost; the CPU must re-issue it.

Optional Feature:
- Macro: BRIDGE_TIMEOUT_EN.
- Defined:
  - In BUSY, if the counter equals TIMEOUT-1 and DEV_Ack[k]=0 at an edge: drop DEV_Req, rd_q = 0, enter RESP with BusErr = 1.
  - If the ack arrives in that same cycle, the ack wins and BusErr = 0.
- Not defined:
  - No counter is synthesised and BUSY waits indefinitely for DEV_Ack[k].
  - BusErr is tied to 0.

Test Plan:
- Read hit, NDEV=2: PrAddr=0x7f14, PrWE=0; device 1 acks in its first DEV_Req cycle with RD=0xCAFE0001.
  - DEV_Req=2'b10 and DEV_Addr=2'b01 at cycle 1.
  - PrRdy=1 and PrRD=0xCAFE0001 at cycle 2; BusErr=0.
- Write with 3 wait states: PrAddr=0x7f08, PrWD=0x12345678, PrWE=1; device 0 acks 3 cycles after DEV_Req rises.
  - DEV_WE=2'b01 and DEV_WD=0x12345678 held through BUSY.
  - PrRdy pulses exactly once.
- Miss: PrAddr=0x7f20 read.
  - PrRdy at cycle 1 with PrRD=0; DEV_Req stays 0 throughout.
- Timeout with BRIDGE_TIMEOUT_EN and TIMEOUT=16, device 0 never acks:
  - DEV_Req high for 16 cycles, then PrRdy=1, BusErr=1, PrRD=0.
  - Repeat with the ack in the 16th cycle: BusErr=0.
- Reset mid-BUSY: assert reset two cycles into a waiting access.
  - DEV_Req, PrRdy and BusErr drop to 0 immediately, without waiting for clk.
  - After release, a new read of 0x7f04 completes normally.
- Interrupts: IRQ=2'b10 -> HWInt=6'b000010; toggling IRQ during BUSY does not disturb the handshake.

Source files
------------

// File: rtl/sys_bridge_nd.sv
// CPU data-port bridge to NDEV 16-byte peripheral windows with req/ack wait states.
// Optional access timeout with bus error enabled by BRIDGE_TIMEOUT_EN.
module sys_bridge_nd #(
  parameter int          NDEV    = 2,
  parameter logic [11:0] BASE    = 12'h7f0,
  parameter int          TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          PrAddr,
  input  logic [31:0]          PrWD,
  input  logic                 PrWE,
  input  logic                 PrReq,
  output logic                 PrRdy,
  output logic [31:0]          PrRD,
  output logic                 BusErr,
  output logic [1:0]           DEV_Addr,
  output logic [31:0]          DEV_WD,
  output logic [NDEV-1:0]      DEV_Req,
  output logic [NDEV-1:0]      DEV_WE,
  input  logic [NDEV-1:0]      DEV_Ack,
  input  logic [32*NDEV-1:0]   DEV_RD,
  input  logic [NDEV-1:0]      IRQ,
  output logic [5:0]           HWInt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [2:0]  r_sel;
  logic [1:0]  r_addr;
  logic [31:0] r_wd;
  logic        r_we;
  logic [31:0] r_rd;

  logic        w_hit;
  logic [2:0]  w_hit_idx;
  logic        w_ack;
  logic [31:0] w_rd;
  logic        w_unused;

  // Device windows are contiguous, so at most one k can match.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = 3'd0;
    for (int k = 0; k < NDEV; k++) begin
      if (PrAddr[15:4] == 12'(BASE + 12'(k))) begin
        w_hit     = 1'b1;
        w_hit_idx = 3'(k);
      end
    end
  end

  always_comb begin
    w_ack = 1'b0;
    w_rd  = 32'd0;
    for (int k = 0; k < NDEV; k++) begin
      if (r_sel == 3'(k)) begin
        w_ack = DEV_Ack[k];
        w_rd  = DEV_RD[32*k +: 32];
      end
    end
  end

  always_comb begin
    DEV_Req = '0;
    DEV_WE  = '0;
    for (int k = 0; k < NDEV; k++) begin
      DEV_Req[k] = (r_state == S_BUSY) && (r_sel == 3'(k));
      DEV_WE[k]  = (r_state == S_BUSY) && (r_sel == 3'(k)) && r_we;
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] r_cnt;
  logic          r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_sel   <= 3'd0;
      r_addr  <= 2'd0;
      r_wd    <= 32'd0;
      r_we    <= 1'b0;
      r_rd    <= 32'd0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_err <= 1'b0;
          if (PrReq) begin
            if (w_hit) begin
              r_sel   <= w_hit_idx;
              r_addr  <= PrAddr[3:2];
              r_wd    <= PrWD;
              r_we    <= PrWE;
              r_cnt   <= '0;
              r_state <= S_BUSY;
            end else begin
              r_rd    <= 32'd0;
              r_state <= S_RESP;
            end
          end
        end
        S_BUSY: begin
          // A late ack in the final cycle still wins over the abort.
          if (w_ack) begin
            r_rd    <= w_rd;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_rd    <= 32'd0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign BusErr   = (r_state == S_RESP) && r_err;
  assign w_unused = ^{PrAddr[31:16], PrAddr[1:0]};
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_sel   <= 3'd0;
      r_addr  <= 2'd0;
      r_wd    <= 32'd0;
      r_we    <= 1'b0;
      r_rd    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (PrReq) begin
            if (w_hit) begin
              r_sel   <= w_hit_idx;
              r_addr  <= PrAddr[3:2];
              r_wd    <= PrWD;
              r_we    <= PrWE;
              r_state <= S_BUSY;
            end else begin
              r_rd    <= 32'd0;
              r_state <= S_RESP;
            end
          end
        end
        S_BUSY: begin
          if (w_ack) begin
            r_rd    <= w_rd;
            r_state <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign BusErr   = 1'b0;
  assign w_unused = ^{PrAddr[31:16], PrAddr[1:0], TIMEOUT[0]};
`endif

  assign PrRdy    = (r_state == S_RESP);
  assign PrRD     = r_rd;
  assign DEV_Addr = r_addr;
  assign DEV_WD   = r_wd;
  assign HWInt    = 6'(IRQ);

endmodule

// File: tb/tb_sys_bridge_nd.sv
// Scoreboard bench for sys_bridge_nd (NDEV=2); timeout cases
// run only when BRIDGE_TIMEOUT_EN is defined.
module tb_sys_bridge_nd;

  localparam int NDEV    = 2;
  localparam int TIMEOUT = 16;
  localparam int BOUND   = 40;

  logic        clk;
  logic        reset;
  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWE;
  logic        PrReq;
  logic        PrRdy;
  logic [31:0] PrRD;
  logic        BusErr;
  logic [1:0]  DEV_Addr;
  logic [31:0] DEV_WD;
  logic [1:0]  DEV_Req;
  logic [1:0]  DEV_WE;
  logic [1:0]  DEV_Ack;
  logic [63:0] DEV_RD;
  logic [1:0]  IRQ;
  logic [5:0]  HWInt;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  sys_bridge_nd #(
    .NDEV   (NDEV),
    .BASE   (12'h7f0),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .PrAddr  (PrAddr),
    .PrWD    (PrWD),
    .PrWE    (PrWE),
    .PrReq   (PrReq),
    .PrRdy   (PrRdy),
    .PrRD    (PrRD),
    .BusErr  (BusErr),
    .DEV_Addr(DEV_Addr),
    .DEV_WD  (DEV_WD),
    .DEV_Req (DEV_Req),
    .DEV_WE  (DEV_WE),
    .DEV_Ack (DEV_Ack),
    .DEV_RD  (DEV_RD),
    .IRQ     (IRQ),
    .HWInt   (HWInt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // wait_n < 0 means the device never acks.
  task automatic run_access(
    input string       nm,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic        we,
    input bit          hit,
    input int          dev,
    input int          wait_n,
    input logic [31:0] rdv,
    input logic        err,
    input bit          wrong_ack,
    input bit          irq_tog
  );
    int          busy;
    int          lat;
    int          exp_lat;
    exp_t        e;
    exp_t        got;
    logic [1:0]  oh;
    oh = 2'b01 << dev;
    @(negedge clk);
    PrAddr  = addr;
    PrWD    = wd;
    PrWE    = we;
    PrReq   = 1'b1;
    DEV_Ack = 2'b00;
    DEV_RD  = {32'hBAD1_BAD1, 32'hBAD0_BAD0};
    if (hit) DEV_RD[32*dev +: 32] = rdv;
    e.rd  = (hit && !err) ? rdv : 32'd0;
    e.err = err;
    sb.push_back(e);
    busy = 0;
    lat  = 0;
    for (int c = 1; c <= BOUND && lat == 0; c++) begin
      @(posedge clk);
      #1;
      PrWD = $urandom;
      if (irq_tog) begin
        IRQ = IRQ ^ 2'b11;
        #1;
        total++;
        if (HWInt !== {4'b0000, IRQ}) begin
          bad++;
          $display("FAIL %s hwint got=%b want=%b", nm, HWInt, {4'b0000, IRQ});
        end
      end
      if (PrRdy) begin
        lat = c;
        PrReq   = 1'b0;
        DEV_Ack = 2'b00;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL %s unexpected PrRdy", nm);
        end else begin
          got = sb.pop_front();
          if (PrRD !== got.rd || BusErr !== got.err) begin
            bad++;
            $display("FAIL %s resp got=%h/%b want=%h/%b",
                     nm, PrRD, BusErr, got.rd, got.err);
          end
        end
      end else if (DEV_Req !== 2'b00) begin
        busy++;
        total++;
        if (!hit || DEV_Req !== oh || DEV_WE !== (we ? oh : 2'b00) ||
            DEV_WD !== wd || DEV_Addr !== addr[3:2]) begin
          bad++;
          $display("FAIL %s busy req=%b we=%b wd=%h a=%b want %b/%b/%h/%b",
                   nm, DEV_Req, DEV_WE, DEV_WD, DEV_Addr,
                   hit ? oh : 2'b00, we ? oh : 2'b00, wd, addr[3:2]);
        end
        if (wrong_ack && busy == 1) DEV_Ack = ~oh;
        if (wait_n >= 0 && busy == wait_n + 1) DEV_Ack = oh;
      end
    end
    if (!hit) exp_lat = 1;
    else if (wait_n >= 0) exp_lat = wait_n + 2;
    else exp_lat = TIMEOUT + 1;
    total++;
    if (lat != exp_lat) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", nm, lat, exp_lat);
    end
    total++;
    if (busy != (hit ? exp_lat - 1 : 0)) begin
      bad++;
      $display("FAIL %s busy cycles got=%0d want=%0d",
               nm, busy, hit ? exp_lat - 1 : 0);
    end
    if (lat == 0) begin
      PrReq   = 1'b0;
      DEV_Ack = 2'b00;
      sb.delete();
    end
    @(posedge clk);
    #1;
    total++;
    if (PrRdy !== 1'b0 || BusErr !== 1'b0 || DEV_Req !== 2'b00) begin
      bad++;
      $display("FAIL %s after rdy=%b err=%b req=%b want 0/0/00",
               nm, PrRdy, BusErr, DEV_Req);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    PrAddr  = 32'd0;
    PrWD    = 32'd0;
    PrWE    = 1'b0;
    PrReq   = 1'b0;
    DEV_Ack = 2'b00;
    DEV_RD  = 64'd0;
    IRQ     = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (PrRdy !== 1'b0 || PrRD !== 32'd0 || BusErr !== 1'b0 ||
        DEV_Req !== 2'b00 || DEV_WE !== 2'b00 ||
        DEV_WD !== 32'd0 || DEV_Addr !== 2'b00) begin
      bad++;
      $display("FAIL reset outputs rdy=%b rd=%h err=%b req=%b we=%b wd=%h a=%b want zeros",
               PrRdy, PrRD, BusErr, DEV_Req, DEV_WE, DEV_WD, DEV_Addr);
    end
    total++;
    if (HWInt !== 6'b000001) begin
      bad++;
      $display("FAIL reset hwint got=%b want=000001", HWInt);
    end
    @(negedge clk);
    reset = 1'b1;
    IRQ   = 2'b00;
  endtask

  task automatic test_read_hit();
    run_access("read_hit", 32'h0000_7f14, 32'h0, 1'b0, 1'b1, 1, 0,
               32'hCAFE_0001, 1'b0, 1'b0, 1'b0);
    run_access("read_hi_bits", 32'hABCD_7f1C, 32'h0, 1'b0, 1'b1, 1, 1,
               32'h5555_AAAA, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_write_wait();
    run_access("write_wait3", 32'h0000_7f08, 32'h1234_5678, 1'b1, 1'b1, 0, 3,
               32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_miss();
    run_access("miss_read", 32'h0000_7f20, 32'h0, 1'b0, 1'b0, 0, 0,
               32'h0, 1'b0, 1'b0, 1'b0);
    run_access("miss_write", 32'h0000_7ef0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0,
               32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrong_ack();
    run_access("wrong_ack", 32'h0000_7f00, 32'h0, 1'b0, 1'b1, 0, 2,
               32'h1111_2222, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen;
    exp_t       e;
    exp_t       got;
    @(negedge clk);
    PrAddr = 32'h0000_7f30;
    PrWE   = 1'b0;
    PrReq  = 1'b1;
    e.rd   = 32'd0;
    e.err  = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      seen[c] = PrRdy;
      if (PrRdy && sb.size() != 0) begin
        got = sb.pop_front();
        total++;
        if (PrRD !== got.rd || BusErr !== got.err) begin
          bad++;
          $display("FAIL b2b resp got=%h/%b want=%h/%b",
                   PrRD, BusErr, got.rd, got.err);
        end
      end
    end
    PrReq = 1'b0;
    total++;
    if (seen !== 4'b0101) begin
      bad++;
      $display("FAIL b2b rdy pattern got=%b want=0101", seen);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL b2b leftover got=%0d want=0", sb.size());
      sb.delete();
    end
    @(posedge clk);
  endtask

  task automatic test_irq();
    @(negedge clk);
    IRQ = 2'b10;
    #1;
    total++;
    if (HWInt !== 6'b000010) begin
      bad++;
      $display("FAIL irq static got=%b want=000010", HWInt);
    end
    run_access("irq_toggle", 32'h0000_7f14, 32'h0, 1'b0, 1'b1, 1, 3,
               32'h7777_0001, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    PrAddr  = 32'h0000_7f0C;
    PrWD    = 32'hDEAD_BEEF;
    PrWE    = 1'b1;
    PrReq   = 1'b1;
    DEV_Ack = 2'b00;
    IRQ     = 2'b11;
    repeat (2) begin
      @(posedge clk);
      #1;
      total++;
      if (DEV_Req !== 2'b01) begin
        bad++;
        $display("FAIL rst_mid pre req=%b want=01", DEV_Req);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (DEV_Req !== 2'b00 || DEV_WE !== 2'b00 || PrRdy !== 1'b0 ||
        BusErr !== 1'b0 || DEV_WD !== 32'd0 || DEV_Addr !== 2'b00) begin
      bad++;
      $display("FAIL rst_mid async req=%b we=%b rdy=%b err=%b wd=%h a=%b want zeros",
               DEV_Req, DEV_WE, PrRdy, BusErr, DEV_WD, DEV_Addr);
    end
    total++;
    if (HWInt !== 6'b000011) begin
      bad++;
      $display("FAIL rst_mid hwint got=%b want=000011", HWInt);
    end
    PrReq = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    IRQ   = 2'b00;
    run_access("after_reset", 32'h0000_7f04, 32'h0, 1'b0, 1'b1, 0, 0,
               32'h0404_0404, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    run_access("timeout", 32'h0000_7f00, 32'h0, 1'b0, 1'b1, 0, -1,
               32'hFFFF_0000, 1'b1, 1'b0, 1'b0);
    run_access("ack_last", 32'h0000_7f00, 32'h0, 1'b0, 1'b1, 0, TIMEOUT - 1,
               32'h1600_0016, 1'b0, 1'b0, 1'b0);
  endtask
`else
  task automatic test_long_wait();
    run_access("long_wait", 32'h0000_7f10, 32'h0, 1'b0, 1'b1, 1, 24,
               32'h2424_2424, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_read_hit();
    test_write_wait();
    test_miss();
    test_wrong_ack();
    test_back_to_back();
    test_irq();
    test_reset_mid_busy();
`ifdef BRIDGE_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
